// File: rtl/latch_cmd_gen.sv
// latch_cmd_gen
// Command stage in front of the run/stop SR latch of the microwave controller.
// The raw front-panel inputs are synchronised, debounced and edge-detected.
// The resulting events become active-low set (S) and reset (R) pulses. S and R
// are never low together.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a debounced input
//                    flips (1..255)
//   PULSE_CYCLES     cycles S or R is held low per command (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start_btn  raw start button, active-high, asynchronous
//   stop_btn   raw stop/clear button, active-high, asynchronous
//   door_open  raw door switch (1 = open), asynchronous
//   S          active-low set to latch (1 = idle)
//   R          active-low reset to latch (1 = idle)
//   busy       high while a pulse or the trailing gap is in progress
//
// Optional feature: define LATCH_CMD_DOOR_INTERLOCK_EN to debounce door_open.
// In that build a door-open event issues a reset pulse, and start is blocked
// while the door is debounced-open. Without the macro door_open is ignored.
module latch_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic door_open,
  output logic S,
  output logic R,
  output logic busy
);

`ifdef LATCH_CMD_DOOR_INTERLOCK_EN
  localparam int NUM_IN = 3;
`else
  localparam int NUM_IN = 2;
`endif

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PLOAD    = 4'(PULSE_CYCLES - 1);

  // Lane 0 = start, lane 1 = stop, lane 2 = door (interlock build only)
  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] db;
  logic [NUM_IN-1:0] evt;

  assign raw[0] = start_btn;
  assign raw[1] = stop_btn;

  logic door_db;
  logic door_evt;
  logic unused_sig;

`ifdef LATCH_CMD_DOOR_INTERLOCK_EN
  assign raw[2]     = door_open;
  assign door_db    = db[2];
  assign door_evt   = evt[2];
  assign unused_sig = ^db[1:0];
`else
  // The door port is kept for interface compatibility only
  assign door_db    = 1'b0;
  assign door_evt   = 1'b0;
  assign unused_sig = ^{db, door_open};
`endif

  // Per-input conditioning: 2-flop synchroniser, debounce counter,
  // debounced level and a one-cycle rising-edge event.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    logic       sync1_q, sync2_q;
    logic [7:0] cnt_q;
    logic       db_q, dbp_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= 8'd0;
        db_q    <= 1'b0;
        dbp_q   <= 1'b0;
      end else begin
        sync1_q <= raw[g];
        sync2_q <= sync1_q;
        dbp_q   <= db_q;
        if (sync2_q != db_q) begin
          // The flip happens on the cycle the count would reach the limit
          if (cnt_q == CNT_LAST) begin
            db_q  <= ~db_q;
            cnt_q <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end else begin
          cnt_q <= 8'd0;
        end
      end
    end

    assign db[g]  = db_q;
    assign evt[g] = db_q & ~dbp_q;
  end

  logic start_evt, rst_evt;
  assign start_evt = evt[0] & ~door_db;
  assign rst_evt   = evt[1] | door_evt;

  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_e;

  state_e     state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= 4'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (rst_evt) begin
          state_d = RST_P;
          pcnt_d  = PLOAD;
        end else if (start_evt) begin
          state_d = SET_P;
          pcnt_d  = PLOAD;
        end
      end
      SET_P: begin
        // A stop/door during a set pulse is remembered and served after the gap
        if (rst_evt) pend_d = 1'b1;
        if (pcnt_q == 4'd0) state_d = GAP;
        else                pcnt_d  = pcnt_q - 4'd1;
      end
      RST_P: begin
        if (pcnt_q == 4'd0) state_d = GAP;
        else                pcnt_d  = pcnt_q - 4'd1;
      end
      GAP: begin
        // An event landing in the gap itself counts as pending too
        if (pend_q || rst_evt) begin
          state_d = RST_P;
          pcnt_d  = PLOAD;
        end else begin
          state_d = IDLE;
        end
        pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the registered state only, so S and R can never both
  // be low and a reset returns them to 1 on the reset edge.
  always_comb begin
    S    = 1'b1;
    R    = 1'b1;
    busy = 1'b0;
    case (state_q)
      SET_P:   begin S = 1'b0; busy = 1'b1; end
      RST_P:   begin R = 1'b0; busy = 1'b1; end
      GAP:     busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_latch_cmd_gen.sv
module tb_latch_cmd_gen;
  localparam int D = 4;
  localparam int P = 2;

`ifdef LATCH_CMD_DOOR_INTERLOCK_EN
  localparam bit DOOR_EN = 1'b1;
`else
  localparam bit DOOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start_btn, stop_btn, door_open;
  logic S, R, busy;

  always #5 clk = ~clk;

  latch_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .door_open(door_open), .S(S), .R(R), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: raw sample history per input, debounced levels derived
  // from "last D synchronised samples all disagree since the last flip", and
  // a pulse timeline (start edge + kind) instead of a state machine.
  bit hist0[$], hist1[$], hist2[$];
  bit db_m[3];
  int last_flip[3];
  bit evt_up[3];
  bit have_p, p_set, pend;
  int p_start;
  int k;
  bit exp_s, exp_r, exp_b;
  int s_lo, r_lo, b_hi, s_first;

  function automatic bit raw_at(int i, int j);
    if (j < 0) return 1'b0;
    case (i)
      0: return hist0[j];
      1: return hist1[j];
      default: return hist2[j];
    endcase
  endfunction

  task automatic model_reset();
    k = 0;
    hist0.delete(); hist1.delete(); hist2.delete();
    for (int i = 0; i < 3; i++) begin
      db_m[i] = 1'b0; last_flip[i] = -1; evt_up[i] = 1'b0;
    end
    have_p = 1'b0; p_set = 1'b0; pend = 1'b0; p_start = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit c);
    bit rst_e, st_e, blk, flip;
    hist0.push_back(a); hist1.push_back(b); hist2.push_back(c);
    rst_e = evt_up[1] | (DOOR_EN & evt_up[2]);
    st_e  = evt_up[0];
    blk   = DOOR_EN & db_m[2];
    if (have_p && k == p_start + P + 1) begin
      if (pend || rst_e) begin
        p_start = k; p_set = 1'b0;
      end
      pend = 1'b0;
    end else if (have_p && k <= p_start + P) begin
      if (p_set && rst_e) pend = 1'b1;
    end else begin
      if (rst_e) begin
        have_p = 1'b1; p_start = k; p_set = 1'b0;
      end else if (st_e && !blk) begin
        have_p = 1'b1; p_start = k; p_set = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      flip = (k - D + 1 >= last_flip[i] + 1);
      for (int j = 0; j < D; j++)
        if (raw_at(i, k - 2 - j) == db_m[i]) flip = 1'b0;
      evt_up[i] = 1'b0;
      if (flip) begin
        db_m[i] = ~db_m[i];
        last_flip[i] = k;
        evt_up[i] = db_m[i];
      end
    end
    exp_b = have_p && k >= p_start && k <= p_start + P;
    exp_s = !(have_p && p_set && k >= p_start && k < p_start + P);
    exp_r = !(have_p && !p_set && k >= p_start && k < p_start + P);
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit a, input bit b, input bit c);
    start_btn = a; stop_btn = b; door_open = c;
    @(posedge clk);
    model_step(a, b, c);
    #1;
    chk("S", S, exp_s);
    chk("R", R, exp_r);
    chk("busy", busy, exp_b);
    total++;
    assert (!(S === 1'b0 && R === 1'b0)) else begin
      bad++;
      $error("FAIL S_R_both_low edge=%0d observed=%b%b expected=not 00", k, S, R);
    end
    if (S === 1'b0) begin
      s_lo++;
      if (s_first < 0) s_first = k;
    end
    if (R === 1'b0) r_lo++;
    if (busy === 1'b1) b_hi++;
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; door_open = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_S", S, 1'b1);
      chk("rst_R", R, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    rst = 1'b0;
    model_reset();
    s_lo = 0; r_lo = 0; b_hi = 0; s_first = -1;
  endtask

  initial begin
    bit a, b, c;
    rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; door_open = 1'b0;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    chk_int("idle_busy", b_hi, 0);

    // Clean start held: S low after edges 6 and 7 only
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    chk_int("clean_s_lo", s_lo, 2);
    chk_int("clean_s_first", s_first, 6);
    chk_int("clean_r_lo", r_lo, 0);
    chk_int("clean_busy", b_hi, 3);

    // Glitch of 3 cycles rejected
    do_reset();
    for (int i = 0; i < 20; i++) cyc(i < 3, 0, 0);
    chk_int("glitch3_s_lo", s_lo, 0);
    chk_int("glitch3_busy", b_hi, 0);

    // 4-cycle high accepted
    do_reset();
    for (int i = 0; i < 20; i++) cyc(i < 4, 0, 0);
    chk_int("hold4_s_lo", s_lo, 2);

    // Simultaneous start and stop
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 1, 0);
    chk_int("simul_s_lo", s_lo, 0);
    chk_int("simul_r_lo", r_lo, 2);

    // Stop lands during the set pulse
    do_reset();
    for (int i = 0; i < 25; i++) cyc(1, i >= 1, 0);
    chk_int("pend_s_lo", s_lo, 2);
    chk_int("pend_r_lo", r_lo, 2);
    chk_int("pend_busy", b_hi, 6);

    // Door held open, then a start press
    do_reset();
    for (int i = 0; i < 30; i++) cyc(i >= 10 && i < 16, 0, 1);
    chk_int("door_s_lo", s_lo, DOOR_EN ? 0 : 2);
    chk_int("door_r_lo", r_lo, DOOR_EN ? 2 : 0);

    // Reset in the middle of a set pulse
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0);
    chk("midpulse_S_low", S, 1'b0);
    do_reset();

    // Randomised run against the model
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) a = ~a;
      if ($urandom_range(0, 15) == 0) b = ~b;
      if ($urandom_range(0, 23) == 0) c = ~c;
      cyc(a, b, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/latch_cmd_gen.md
Name: latch_cmd_gen

Overview:
- Upstream command stage for the run/stop SR latch in the microwave controller.
- Conditions raw front-panel inputs (start, stop, door): synchronises, debounces and edge-detects them.
- Converts the resulting events into the latch's active-low set/reset pulses S and R.
- Guarantees the latch never sees the forbidden S=0/R=0 combination.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles an input must differ from its debounced value before the debounced value flips; legal range 1..255.
- PULSE_CYCLES, 2: cycles S or R is held low per command; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start_btn  input  1  raw start button, active-high, asynchronous to clk
- stop_btn  input  1  raw stop/clear button, active-high, asynchronous
- door_open  input  1  raw door switch, 1 = open, asynchronous
- S  output  1  active-low set to latch (1 = idle)
- R  output  1  active-low reset to latch (1 = idle)
- busy  output  1  high while a pulse or gap is in progress

Behaviour:
- Reset (rst=1 at an edge):
  - S=1, R=1, busy=0, FSM=IDLE.
  - Sync flops, debounced values, debounce counters and pending flag cleared to 0.
  - Reset mid-pulse aborts the pulse; S/R return to 1 on that same edge.
- Per-input chain:
  - 2-flop synchroniser, then an 8-bit debounce counter, then a debounced register db.
  - Each cycle sync≠db: counter+1. When the counter would reach DEBOUNCE_CYCLES, db flips and the counter clears.
  - Any cycle sync==db: counter clears, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Event = db rising edge (db & ~db_prev), one cycle wide.
- Latency: raw input high before edge 0 and held → db high after edge 1+DEBOUNCE_CYCLES → FSM acts at edge 2+DEBOUNCE_CYCLES. With defaults, S goes low after the 7th edge.
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE: stop_evt or door_evt → RST_P. Else start_evt (and door db=0) → SET_P. Else stay.
  - SET_P: S=0 for PULSE_CYCLES cycles (down-counter), then GAP.
  - RST_P: R=0 for PULSE_CYCLES cycles, then GAP.
  - GAP: S=R=1 for exactly one cycle. Then RST_P if pending set, clearing pending; else IDLE.
- busy=1 in SET_P, RST_P and GAP.
- Priority and simultaneous events:
  - Stop/door beats start in the same cycle; start is dropped.
  - Stop or door event during SET_P or GAP sets pending; a reset pulse follows the gap.
  - Start event while busy is dropped.
  - Stop event during RST_P is dropped; it is redundant.
- Invariant: S and R never both 0 in any cycle, including transitions.
- Start events while door db=1 are ignored. A door-open event acts as stop.
- Level hold on a button produces exactly one event; release produces none.

Optional Feature:
- Macro: LATCH_CMD_DOOR_INTERLOCK_EN.
- Defined: door_open is synchronised and debounced. Door rising edge issues a reset pulse, and start is blocked while the door is debounced-open.
- Undefined:
  - door_open is ignored: no door logic synthesised, door db treated as constant 0.
  - Start is never blocked.
  - Port is kept for interface compatibility.

Test Plan (defaults D=4, P=2):
- Reset then idle: rst=1 for 2 cycles, inputs 0 → S=1, R=1, busy=0 for 20 cycles.
- Clean start: start_btn high from edge 0, held 20 cycles → S=0 in exactly the cycles after edges 6 and 7, S=1 afterward, R=1 throughout. Exactly one pulse; busy high 3 cycles.
- Glitch reject: start_btn high for 3 cycles, then low → S, R stay 1, busy 0. Same stimulus with a 4-cycle high produces one S pulse.
- Simultaneous start+stop: both rise on the same edge → single R pulse of 2 cycles, no S pulse.
- Stop during set pulse: stop debounces so its event lands while S=0 → S pulse completes (2 cycles), 1-cycle gap with S=R=1, then R=0 for 2 cycles. Check S&R never both 0.
- Door interlock (macro defined): door_open=1 held, then start pulse → one R pulse from the door event, no S pulse. Macro undefined, same stimulus → one S pulse, no R pulse.
